// File: rtl/val2_imm_encoder.sv
// val2_imm_encoder
// Finds the Val2 shifter-operand encoding {rotate_imm, imm8} of a 32-bit constant,
// meaning imm8 ROR (2*rotate_imm) == constant. The search tries one rotation per cycle,
// starting at rotate_imm 0, so the smallest matching rotation is the one reported.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high. The producer holds valid (and its data) until that edge. The consumer may
// drive ready at any time. Neither side lets valid depend on ready. in_ready is high
// only in IDLE, and out_valid is high only in DONE, so requests never overlap.
//
// Only DATA_LEN = 32 is meaningful, because rotate amounts are defined for 32 bits.
module val2_imm_encoder #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ok,
  output logic [11:0]         offset,
  output logic [4:0]          rot_tries,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_LEN-1:0] val_q, val_d;
  logic [3:0]          rot_q, rot_d;
  logic                ok_q, ok_d;
  logic [11:0]         offset_q, offset_d;
  logic [4:0]          tries_q, tries_d;

  logic [4:0]          rol_amt;
  logic [DATA_LEN-1:0] cand;
  logic                hit;
  logic                last_rot;

  // Candidate for the current rotation: val_q rotated left by 2*rot. A shift by the
  // full width yields zero, so the rot=0 case reduces to val_q.
  always_comb begin
    rol_amt  = {rot_q, 1'b0};
    cand     = (val_q << rol_amt) | (val_q >> (6'd32 - {1'b0, rol_amt}));
    hit      = (cand[31:8] == 24'd0);
    last_rot = (rot_q == 4'd15);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SEARCH -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)          state_d = ST_SEARCH;
      ST_SEARCH: if (hit || last_rot)   state_d = ST_DONE;
      ST_DONE:   if (out_ready)         state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and debug view, decoded from the current state only.
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    dbg_state_o = state_q;
  end

  // Datapath next values: latch the request, step the rotation, capture the result.
  always_comb begin
    val_d    = val_q;
    rot_d    = rot_q;
    ok_d     = ok_q;
    offset_d = offset_q;
    tries_d  = tries_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          val_d = value;
          rot_d = 4'd0;
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          ok_d     = 1'b1;
          offset_d = {rot_q, cand[7:0]};
          tries_d  = {1'b0, rot_q} + 5'd1;
        end else if (last_rot) begin
          ok_d     = 1'b0;
          offset_d = 12'h000;
          tries_d  = 5'd16;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. Results hold their value through DONE until the handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q    <= '0;
      rot_q    <= 4'd0;
      ok_q     <= 1'b0;
      offset_q <= 12'h000;
      tries_q  <= 5'd0;
    end else begin
      val_q    <= val_d;
      rot_q    <= rot_d;
      ok_q     <= ok_d;
      offset_q <= offset_d;
      tries_q  <= tries_d;
    end
  end

  // Result ports.
  always_comb begin
    ok        = ok_q;
    offset    = offset_q;
    rot_tries = tries_q;
  end

endmodule

// File: tb/tb_val2_imm_encoder.sv
// Testbench for val2_imm_encoder: directed vectors, backpressure, mid-search reset and
// a random sweep, all scored against a reconstruction model of the immediate encoding.
module tb_val2_imm_encoder;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] value = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        ok;
  logic [11:0] offset;
  logic [4:0]  rot_tries;
  logic [1:0]  dbg_state_o;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  val2_imm_encoder #(.DATA_LEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value      (value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ok         (ok),
    .offset     (offset),
    .rot_tries  (rot_tries),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  // Returns {ok, offset[11:0], tries[4:0]}: the first rotation r whose low byte,
  // rotated back right by 2r, rebuilds v exactly.
  function automatic logic [17:0] model_enc(input logic [31:0] v);
    for (int r = 0; r < 16; r++) begin
      logic [31:0] t;
      logic [7:0]  imm;
      logic [3:0]  r4;
      logic [4:0]  tr;
      t   = ror32(v, 32 - 2 * r);
      imm = t[7:0];
      if (ror32({24'h0, imm}, 2 * r) == v) begin
        r4 = 4'(r);
        tr = 5'(r + 1);
        return {1'b1, r4, imm, tr};
      end
    end
    return {1'b0, 12'h000, 5'd16};
  endfunction

  // ---------------- scoreboard ----------------
  // Entry: {value[31:0], ok, offset[11:0], tries[4:0]}
  logic [49:0] exp_q[$];
  int          acc_q[$];
  bit          seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, check the DUT against the expected queue.
  always @(negedge clk) begin
    logic [49:0] e;
    logic [31:0] rec;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1, expected 0 (t=%0t)", $time);
        end else begin
          e = exp_q[0];
          chk("ok", ok, e[17]);
          chk("offset", offset, e[16:5]);
          chk("rot_tries", rot_tries, e[4:0]);
          chk("in_ready_in_done", in_ready, 1'b0);
          if (!seen) begin
            chk("latency", cyc - acc_q[0], e[4:0]);
            seen = 1'b1;
          end
          if (ok) begin
            rec = ror32({24'h0, offset[7:0]}, 2 * offset[11:8]);
            chk("invariant", rec, e[49:18]);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({value, model_enc(value)});
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] v);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    value    = v;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    if (acc) begin
      @(posedge clk); #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
    end
    in_valid = 1'b0;
    value    = $urandom;
  endtask

  task automatic wait_done(input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
      else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    out_ready = 1'b1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_vec [8];

  initial begin
    bit seen_ov;
    logic [31:0] v;

    dir_vec[0] = 32'h000000FF; dir_vec[1] = 32'hFF000000;
    dir_vec[2] = 32'hF000000F; dir_vec[3] = 32'h00000104;
    dir_vec[4] = 32'h00000102; dir_vec[5] = 32'h00000000;
    dir_vec[6] = 32'hFFFFFFFF; dir_vec[7] = 32'h000003FC;

    // Hand-computed pins on the model.
    chk("model_000000FF", model_enc(32'h000000FF), {1'b1, 12'h0FF, 5'd1});
    chk("model_FF000000", model_enc(32'hFF000000), {1'b1, 12'h4FF, 5'd5});
    chk("model_F000000F", model_enc(32'hF000000F), {1'b1, 12'h2FF, 5'd3});
    chk("model_00000104", model_enc(32'h00000104), {1'b1, 12'hF41, 5'd16});
    chk("model_00000102", model_enc(32'h00000102), {1'b0, 12'h000, 5'd16});
    chk("model_00000000", model_enc(32'h00000000), {1'b1, 12'h000, 5'd1});
    chk("model_000003FC", model_enc(32'h000003FC), {1'b1, 12'hFFF, 5'd16});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ok", ok, 1'b0);
    chk("rst_offset", offset, 12'h000);
    chk("rst_rot_tries", rot_tries, 5'd0);
    chk("rst_state", dbg_state_o, 2'd0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      send(dir_vec[i]);
      wait_done(1'b0);
    end

    // Backpressure: hold the result in DONE for 10 cycles with in_valid pulses.
    out_ready = 1'b0;
    send(32'h000000FF);
    seen_ov = 1'b0;
    for (int i = 0; i < 50 && !seen_ov; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    chk("bp_reached_done", seen_ov, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      value    = $urandom;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_offset", offset, 12'h0FF);
      chk("bp_rot_tries", rot_tries, 5'd1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle_in_ready", in_ready, 1'b1);
    chk("bp_back_idle_out_valid", out_valid, 1'b0);

    // Reset in the middle of a search at rot=7.
    send(32'h00000102);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_ok", ok, 1'b0);
    chk("mid_rst_offset", offset, 12'h000);
    chk("mid_rst_rot_tries", rot_tries, 5'd0);
    chk("mid_rst_state", dbg_state_o, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_no_out_valid", out_valid, 1'b0);
    end
    send(32'h00000000);
    wait_done(1'b0);

    // Random sweep, biased toward encodable constants.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) != 0)
        v = ror32({24'h0, 8'($urandom_range(0, 255))}, 2 * $urandom_range(0, 15));
      else
        v = $urandom;
      send(v);
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
